// File: rtl/psram_word_bridge.sv
// psram_word_bridge: a 32-bit host word port onto a 16-bit PSRAM, with posted writes.
// Queued writes always drain before a pending read fetches its two halfwords, low half first.
module psram_word_bridge #(
  parameter int ADDRESS_BITS  = 23,
  parameter int RD_LATENCY    = 4,
  parameter int WR_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-2:0] host_address,
  input  logic                    host_wr,
  input  logic [31:0]             host_wr_data,
  output logic                    host_wr_ready,
  input  logic                    host_rd,
  output logic                    host_rd_ready,
  output logic [31:0]             host_rd_data,
  output logic                    host_rd_valid,
  output logic [ADDRESS_BITS-1:0] ram_rd_address,
  output logic                    ram_rd_en,
  input  logic                    ram_rd_ack,
  input  logic [15:0]             ram_rd_data,
  output logic [ADDRESS_BITS-1:0] ram_wr_address,
  output logic                    ram_wr_en,
  output logic [15:0]             ram_wr_data,
  input  logic                    ram_wr_ack,
  output logic                    busy
);

  localparam int PW = $clog2(WR_FIFO_DEPTH);
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam logic [PW:0]   DEPTH_C = WR_FIFO_DEPTH[PW:0];
  localparam logic [CW-1:0] LAT_C   = RD_LATENCY[CW-1:0];

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, RD_LO, RD_LO_WAIT, RD_HI, RD_HI_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-2:0] fifo_addr_q [WR_FIFO_DEPTH];
  logic [31:0]             fifo_data_q [WR_FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]             count_q, count_d;
  logic                    rd_pending_q, rd_pending_d;
  logic [ADDRESS_BITS-2:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [15:0]             rd_lo_q, rd_lo_d;
  logic [31:0]             host_rd_data_q, host_rd_data_d;
  logic                    host_rd_valid_q, host_rd_valid_d;

  logic                    push, pop, rd_accept, rd_clear, fifo_empty;
  logic [ADDRESS_BITS-2:0] head_addr;
  logic [31:0]             head_data;

  assign fifo_empty    = (count_q == '0);
  assign host_wr_ready = (count_q < DEPTH_C);
  assign host_rd_ready = !rd_pending_q;
  assign push          = host_wr && host_wr_ready;
  assign rd_accept     = host_rd && host_rd_ready;
  assign head_addr     = fifo_addr_q[rd_ptr_q];
  assign head_data     = fifo_data_q[rd_ptr_q];
  assign busy          = (state_q != IDLE) || !fifo_empty || rd_pending_q;
  assign host_rd_data  = host_rd_data_q;
  assign host_rd_valid = host_rd_valid_q;

  // Posted-write storage; unreset because the count gates every use of an entry.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= host_address;
      fifo_data_q[wr_ptr_q] <= host_wr_data;
    end
  end

  // FIFO pointers/count and read-request latch.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    rd_addr_d    = rd_accept ? host_address : rd_addr_q;
    rd_pending_d = rd_pending_q;
    if (rd_clear) begin
      rd_pending_d = 1'b0;
    end else if (rd_accept) begin
      rd_pending_d = 1'b1;
    end else begin
      rd_pending_d = rd_pending_q;
    end
  end

  // Sequencer: next state, RAM strobes and read assembly.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rd_lo_d         = rd_lo_q;
    host_rd_data_d  = host_rd_data_q;
    host_rd_valid_d = 1'b0;
    pop             = 1'b0;
    rd_clear        = 1'b0;
    ram_rd_en       = 1'b0;
    ram_rd_address  = '0;
    ram_wr_en       = 1'b0;
    ram_wr_address  = '0;
    ram_wr_data     = 16'h0000;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = WR_LO;
        end else if (rd_pending_q) begin
          state_d = RD_LO;
        end else begin
          state_d = IDLE;
        end
      end
      WR_LO: begin
        ram_wr_en      = 1'b1;
        ram_wr_address = {head_addr, 1'b0};
        ram_wr_data    = head_data[15:0];
        state_d        = ram_wr_ack ? WR_HI : WR_LO;
      end
      WR_HI: begin
        ram_wr_en      = 1'b1;
        ram_wr_address = {head_addr, 1'b1};
        ram_wr_data    = head_data[31:16];
        if (ram_wr_ack) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WR_HI;
        end
      end
      RD_LO, RD_HI: begin
        ram_rd_en      = 1'b1;
        ram_rd_address = {rd_addr_q, (state_q == RD_HI)};
        if (ram_rd_ack) begin
          cnt_d   = CW'(1);
          state_d = (state_q == RD_HI) ? RD_HI_WAIT : RD_LO_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      RD_LO_WAIT, RD_HI_WAIT: begin
        if (cnt_q == LAT_C) begin
          cnt_d = '0;
          if (state_q == RD_HI_WAIT) begin
            host_rd_data_d  = {ram_rd_data, rd_lo_q};
            host_rd_valid_d = 1'b1;
            rd_clear        = 1'b1;
            state_d         = IDLE;
          end else begin
            rd_lo_d = ram_rd_data;
            state_d = RD_HI;
          end
        end else if (cnt_q < LAT_C) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      rd_pending_q    <= 1'b0;
      rd_addr_q       <= '0;
      cnt_q           <= '0;
      rd_lo_q         <= 16'h0000;
      host_rd_data_q  <= 32'h0000_0000;
      host_rd_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      rd_pending_q    <= rd_pending_d;
      rd_addr_q       <= rd_addr_d;
      cnt_q           <= cnt_d;
      rd_lo_q         <= rd_lo_d;
      host_rd_data_q  <= host_rd_data_d;
      host_rd_valid_q <= host_rd_valid_d;
    end
  end

endmodule

// File: tb/tb_psram_word_bridge.sv
// Scoreboard bench for psram_word_bridge: directed host traffic against a small PSRAM model.
module tb_psram_word_bridge;

  localparam int AB  = 23;
  localparam int LAT = 4;

  typedef struct packed {
    logic [AB-1:0] a;
    logic [15:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AB-2:0] host_address = '0;
  logic          host_wr = 1'b0;
  logic [31:0]   host_wr_data = 32'h0;
  logic          host_wr_ready;
  logic          host_rd = 1'b0;
  logic          host_rd_ready;
  logic [31:0]   host_rd_data;
  logic          host_rd_valid;
  logic [AB-1:0] ram_rd_address;
  logic          ram_rd_en;
  logic          ram_rd_ack;
  logic [15:0]   ram_rd_data;
  logic [AB-1:0] ram_wr_address;
  logic          ram_wr_en;
  logic [15:0]   ram_wr_data;
  logic          ram_wr_ack;
  logic          busy;
  logic          wr_ack_en = 1'b1;

  wr_t           exp_wr_q [$];
  logic [31:0]   exp_rd_q [$];
  logic [15:0]   ram_mem [logic [AB-1:0]];
  int            checks = 0;
  int            failures = 0;
  int            rd_hs_count = 0;
  int            rd_delay = 0;
  logic [15:0]   rd_word = 16'h0;
  logic          prev_valid = 1'b0;
  logic          prev_rd_en = 1'b0;
  logic [31:0]   last_rd = 32'h0;
  wr_t           e;

  psram_word_bridge #(.ADDRESS_BITS(AB), .RD_LATENCY(LAT), .WR_FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .host_address(host_address), .host_wr(host_wr), .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready), .host_rd(host_rd), .host_rd_ready(host_rd_ready),
    .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
    .ram_rd_address(ram_rd_address), .ram_rd_en(ram_rd_en), .ram_rd_ack(ram_rd_ack),
    .ram_rd_data(ram_rd_data), .ram_wr_address(ram_wr_address), .ram_wr_en(ram_wr_en),
    .ram_wr_data(ram_wr_data), .ram_wr_ack(ram_wr_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  assign ram_wr_ack = wr_ack_en & ram_wr_en;
  assign ram_rd_ack = ram_rd_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] mem_read(input logic [AB-1:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : 16'h0000;
  endfunction

  // PSRAM read model: data appears exactly LAT cycles after the accepting edge, junk otherwise.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_delay    <= 0;
      ram_rd_data <= 16'hA5A5;
    end else if (ram_rd_en && ram_rd_ack) begin
      rd_word     <= mem_read(ram_rd_address);
      rd_delay    <= LAT - 1;
      ram_rd_data <= 16'hA5A5;
    end else if (rd_delay > 0) begin
      rd_delay    <= rd_delay - 1;
      ram_rd_data <= (rd_delay == 1) ? rd_word : 16'hA5A5;
    end else begin
      ram_rd_data <= 16'hA5A5;
    end
  end

  // Scoreboard monitor, sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      prev_valid = 1'b0;
      prev_rd_en = 1'b0;
      last_rd    = 32'h0;
    end else begin
      chk("en_exclusive", 64'(ram_rd_en & ram_wr_en), 64'd0);
      if (!ram_rd_en) chk("rd_addr_idle_zero", 64'(ram_rd_address), 64'd0);
      if (!ram_wr_en) begin
        chk("wr_addr_idle_zero", 64'(ram_wr_address), 64'd0);
        chk("wr_data_idle_zero", 64'(ram_wr_data), 64'd0);
      end
      if (ram_wr_en && ram_wr_ack) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ram_wr actual=%0h/%0h required=none", ram_wr_address, ram_wr_data);
        end else begin
          e = exp_wr_q.pop_front();
          chk("ram_wr_addr", 64'(ram_wr_address), 64'(e.a));
          chk("ram_wr_data", 64'(ram_wr_data), 64'(e.d));
        end
        ram_mem[ram_wr_address] = ram_wr_data;
      end
      if (ram_rd_en && !prev_rd_en) chk("raw_order_pending_writes", 64'(exp_wr_q.size()), 64'd0);
      if (ram_rd_en && ram_rd_ack) rd_hs_count++;
      if (host_rd_valid) begin
        chk("rd_valid_single_cycle", 64'(prev_valid), 64'd0);
        if (exp_rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rd_valid actual=%0h required=none", host_rd_data);
        end else begin
          chk("host_rd_data", 64'(host_rd_data), 64'(exp_rd_q.pop_front()));
        end
        last_rd = host_rd_data;
      end else begin
        chk("rd_data_hold", 64'(host_rd_data), 64'(last_rd));
      end
      prev_valid = host_rd_valid;
      prev_rd_en = ram_rd_en;
    end
  end

  task automatic exp_wr(input logic [AB-1:0] a, input logic [15:0] d);
    exp_wr_q.push_back(wr_t'{a: a, d: d});
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_wr_ready"}, 64'(host_wr_ready), 64'd1);
    chk({tag, "_rd_ready"}, 64'(host_rd_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ram_rd_en"}, 64'(ram_rd_en), 64'd0);
    chk({tag, "_ram_wr_en"}, 64'(ram_wr_en), 64'd0);
    chk({tag, "_rd_valid"}, 64'(host_rd_valid), 64'd0);
    chk({tag, "_rd_data"}, 64'(host_rd_data), 64'd0);
    chk({tag, "_ram_rd_addr"}, 64'(ram_rd_address), 64'd0);
    chk({tag, "_ram_wr_addr"}, 64'(ram_wr_address), 64'd0);
  endtask

  task automatic do_write(input logic [AB-2:0] a, input logic [31:0] d, input logic rdy, input string name);
    @(negedge clk);
    host_address = a;
    host_wr_data = d;
    host_wr      = 1'b1;
    chk(name, 64'(host_wr_ready), 64'(rdy));
  endtask

  task automatic do_read(input logic [AB-2:0] a, input logic rdy, input string name);
    @(negedge clk);
    host_address = a;
    host_rd      = 1'b1;
    chk(name, 64'(host_rd_ready), 64'(rdy));
  endtask

  task automatic release_host();
    @(negedge clk);
    host_wr = 1'b0;
    host_rd = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    chk({name, "_busy_done"}, 64'(busy), 64'd0);
    chk({name, "_wr_drained"}, 64'(exp_wr_q.size()), 64'd0);
    chk({name, "_rd_drained"}, 64'(exp_rd_q.size()), 64'd0);
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(negedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    reset = 1'b0;

    // Single write
    exp_wr(23'h2468A, 16'hBEEF);
    exp_wr(23'h2468B, 16'hDEAD);
    do_write(22'h12345, 32'hDEADBEEF, 1'b1, "single_wr_ready");
    release_host();
    wait_idle("single_wr");

    // Same-cycle write and read of one word
    exp_wr(23'h00020, 16'hF00D);
    exp_wr(23'h00021, 16'hCAFE);
    exp_rd_q.push_back(32'hCAFEF00D);
    @(negedge clk);
    host_address = 22'h00010;
    host_wr_data = 32'hCAFEF00D;
    host_wr      = 1'b1;
    host_rd      = 1'b1;
    chk("raw_wr_ready", 64'(host_wr_ready), 64'd1);
    chk("raw_rd_ready", 64'(host_rd_ready), 64'd1);
    release_host();
    wait_idle("raw");

    // Full FIFO with write acks held off
    wr_ack_en = 1'b0;
    exp_wr(23'h00200, 16'h2222); exp_wr(23'h00201, 16'h1111);
    exp_wr(23'h00202, 16'h4444); exp_wr(23'h00203, 16'h3333);
    exp_wr(23'h00204, 16'h6666); exp_wr(23'h00205, 16'h5555);
    exp_wr(23'h00206, 16'h8888); exp_wr(23'h00207, 16'h7777);
    do_write(22'h00100, 32'h11112222, 1'b1, "full_wr0_ready");
    do_write(22'h00101, 32'h33334444, 1'b1, "full_wr1_ready");
    do_write(22'h00102, 32'h55556666, 1'b1, "full_wr2_ready");
    do_write(22'h00103, 32'h77778888, 1'b1, "full_wr3_ready");
    do_write(22'h00104, 32'h9999AAAA, 1'b0, "full_wr4_ready");
    release_host();
    repeat (3) @(negedge clk);
    chk("full_ready_stays_low", 64'(host_wr_ready), 64'd0);
    wr_ack_en = 1'b1;
    wait_idle("full");

    // Read latency and halfword assembly
    ram_mem[23'h00400] = 16'h1111;
    ram_mem[23'h00401] = 16'h2222;
    exp_rd_q.push_back(32'h22221111);
    do_read(22'h00200, 1'b1, "lat_rd_ready");
    release_host();
    wait_idle("lat");

    // A second read while one is pending is refused
    ram_mem[23'h00600] = 16'h3333;
    ram_mem[23'h00601] = 16'h4444;
    exp_rd_q.push_back(32'h44443333);
    base = rd_hs_count;
    do_read(22'h00300, 1'b1, "pend_rd0_ready");
    do_read(22'h00301, 1'b0, "pend_rd1_ready");
    release_host();
    wait_idle("pend");
    chk("pend_ram_rd_count", 64'(rd_hs_count - base), 64'd2);

    // Reset while waiting on the high halfword
    ram_mem[23'h00A00] = 16'h5555;
    ram_mem[23'h00A01] = 16'h6666;
    do_read(22'h00500, 1'b1, "mid_rd_ready");
    release_host();
    n = 0;
    while (!(ram_rd_en && ram_rd_ack && ram_rd_address == 23'h00A01) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_hi", 64'(n < 100), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    reset_checks("midrst");
    repeat (2) @(negedge clk);
    #1;
    reset_checks("midrst_hold");
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    exp_rd_q.push_back(32'h66665555);
    do_read(22'h00500, 1'b1, "post_rst_rd_ready");
    release_host();
    wait_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/psram_word_bridge.md
PSRAM_WORD_BRIDGE -- requirements
Module: psram_word_bridge

Interface
REQ-001 Parameters SHALL be: ADDRESS_BITS, default 23, the RAM halfword address width including the bank bit. RD_LATENCY, default 4, the cycles after ram_rd_ack before ram_rd_data is valid. WR_FIFO_DEPTH, default 4, the number of posted-write entries (a power of 2, at least 2).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-003 Ports SHALL be as follows (clock and reset first):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- host_address  in  ADDRESS_BITS-1  32-bit word address
- host_wr  in  1  write request
- host_wr_data  in  32  write data
- host_wr_ready  out  1  write accepted when high with host_wr
- host_rd  in  1  read request
- host_rd_ready  out  1  read accepted when high with host_rd
- host_rd_data  out  32  read data
- host_rd_valid  out  1  one-cycle read-complete pulse
- ram_rd_address  out  ADDRESS_BITS  halfword read address
- ram_rd_en  out  1  RAM read request
- ram_rd_ack  in  1  RAM read accepted
- ram_rd_data  in  16  RAM read data
- ram_wr_address  out  ADDRESS_BITS  halfword write address
- ram_wr_en  out  1  RAM write request
- ram_wr_data  out  16  RAM write data
- ram_wr_ack  in  1  RAM write accepted
- busy  out  1  work outstanding

Function
REQ-004 Halfword addresses SHALL be {host_address, h}, where h=0 carries data[15:0] and h=1 carries data[31:16]; the low half SHALL always be issued first.
REQ-005 A write SHALL be accepted into the FIFO on any cycle where host_wr && host_wr_ready; host_wr_ready SHALL equal (fifo count < WR_FIFO_DEPTH).
REQ-006 A simultaneous FIFO push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo WR_FIFO_DEPTH; a push while full SHALL be impossible.
REQ-007 A read SHALL be accepted when host_rd && host_rd_ready; host_rd_ready SHALL be !rd_pending; acceptance SHALL latch the address and set rd_pending.
REQ-008 A write and a read accepted in the same cycle SHALL both be accepted, with the write ordered first.
REQ-009 Every FIFO entry present when a read is accepted SHALL be completed in RAM before ram_rd_en rises (read-after-write ordering).
REQ-010 FSM states SHALL be IDLE, WR_LO, WR_HI, RD_LO, RD_LO_WAIT, RD_HI, RD_HI_WAIT.
REQ-011 From IDLE the FSM SHALL go to WR_LO if the FIFO is non-empty, else to RD_LO if rd_pending, else stay in IDLE.
REQ-012 In WR_LO and WR_HI, ram_wr_en SHALL be 1 with address and data from the FIFO head, held stable until ram_wr_ack. On ack, WR_LO SHALL go to WR_HI; WR_HI SHALL pop the FIFO and go to IDLE.
REQ-013 In RD_LO and RD_HI, ram_rd_en SHALL be 1 and held until ram_rd_ack. On ack, the FSM SHALL go to the matching WAIT state with the latency counter set to 1.
REQ-014 In the WAIT states the counter SHALL increment each cycle. When the counter equals RD_LATENCY, ram_rd_data SHALL be captured into the low half (then go to RD_HI) or the high half (then go to IDLE).
REQ-015 On the high-half capture, rd_pending SHALL clear and host_rd_valid SHALL be 1 for exactly the next cycle; host_rd_data SHALL hold until the next valid pulse.
REQ-016 ram_rd_en and ram_wr_en SHALL never both be high; both SHALL be 0 in IDLE and the WAIT states.
REQ-017 ram_rd_address, ram_wr_address and ram_wr_data SHALL be 0 when the matching enable is low.
REQ-018 busy SHALL be (state != IDLE) || fifo non-empty || rd_pending.
REQ-019 The counter SHALL be $clog2(RD_LATENCY+1) bits and SHALL saturate (never wrap).

Reset
REQ-020 While reset is asserted, the block SHALL hold: state IDLE, FIFO empty, rd_pending 0, counter 0, host_rd_data 0, host_rd_valid 0, ram_rd_en 0, ram_wr_en 0, host_wr_ready 1, host_rd_ready 1, busy 0.
REQ-021 Reset mid-transaction SHALL abandon the transaction without any host_rd_valid pulse; a half-written word is permitted.

Verification
REQ-022 Single write: write host_address 0x12345, data 0xDEADBEEF, RAM model acks immediately -> RAM sees 0x2468A/0xBEEF, then 0x2468B/0xDEAD; busy returns to 0.
REQ-023 Ordering: write 0x00010 with 0xCAFEF00D and read 0x00010 in the same cycle -> both RAM writes complete before ram_rd_en rises; host_rd_data = 0xCAFEF00D with one valid pulse.
REQ-024 Full FIFO: 5 back-to-back writes with ram_wr_ack held 0 -> 4 accepted, host_wr_ready 0 on the 5th; releasing ack yields 8 RAM writes in order.
REQ-025 Latency: with RD_LATENCY=4 and the model driving 0x1111 and 0x2222 exactly 4 cycles after each ack -> host_rd_data = 0x22221111, host_rd_valid high 1 cycle.
REQ-026 Reset during RD_HI_WAIT -> all outputs at reset values, no valid pulse; a subsequent read completes correctly.
REQ-027 A host_rd while rd_pending -> host_rd_ready 0, the request is ignored, and exactly one RAM read pair is issued.
